// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared definitions for the two-port RAM arbiter.
//   RW_READ / RW_WRITE : encoding of the RAM rw line (genram-style, 1 = read).
//   state_e            : arbiter FSM state encoding (2 bits).
package ram_arbiter_pkg;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2
// Combinational two-way round-robin picker.
//   elig[1:0] : in  per-requester eligibility
//   last      : in  index of the most recent winner
//   valid     : out at least one requester is eligible
//   winner    : out index of the chosen requester (meaningful when valid)
module arb_rr2 (
  input  logic [1:0] elig,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |elig;
    winner = 1'b0;
    if (elig == 2'b11) begin
      // Contention: the requester that did not win last time goes next.
      winner = ~last;
    end else begin
      winner = elig[1];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port synchronous RAM (registered read, rw=1 read /
// rw=0 write) between two requesters with round-robin arbitration.
// Each access is a request/acknowledge transaction lasting three cycles.
//   clk, rstn              : clock (rising edge), async active-low reset
//   req0/1, rw0/1          : request (held until ack), access type
//   addr0/1, din0/1        : address and write data, sampled at grant
//   ack0/1                 : one-cycle completion pulse
//   dout0/1                : read data, valid with ack and held afterwards
//   busy                   : FSM is not IDLE
//   ram_addr/ram_rw/ram_din: registered RAM control and write data
//   ram_dout               : RAM read data
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req0,
  input  logic          req1,
  input  logic          rw0,
  input  logic          rw1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] dout0,
  output logic [DW-1:0] dout1,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rw,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          txn_rw_q, txn_rw_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_rw_q, ram_rw_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic [1:0]    ack_q, ack_d;
  logic [DW-1:0] dout0_q, dout0_d;
  logic [DW-1:0] dout1_q, dout1_d;

  logic [1:0]    elig;
  logic          pick_valid;
  logic          pick_winner;

  // A request still high during its own ack cycle must not be re-granted.
  assign elig = {req1 & ~ack_q[1], req0 & ~ack_q[0]};

  arb_rr2 u_arb_rr2 (
    .elig   (elig),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    txn_rw_d   = txn_rw_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    dout0_d    = dout0_q;
    dout1_d    = dout1_q;
    // rw defaults to read so the RAM only ever sees a write in the ACC cycle.
    ram_rw_d   = RW_READ;
    ack_d      = 2'b00;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d      = pick_winner;
          last_d     = pick_winner;
          ram_addr_d = pick_winner ? addr1 : addr0;
          ram_rw_d   = pick_winner ? rw1   : rw0;
          txn_rw_d   = pick_winner ? rw1   : rw0;
          ram_din_d  = pick_winner ? din1  : din0;
          state_d    = ACC;
        end
      end
      ACC: begin
        // The RAM performs the access on this edge; rw returns to read.
        state_d = RESP;
      end
      RESP: begin
        // ram_dout now holds the registered read of the ACC edge.
        if (txn_rw_q == RW_READ) begin
          if (gnt_q) dout1_d = ram_dout;
          else       dout0_d = ram_dout;
        end
        ack_d[gnt_q] = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      txn_rw_q   <= RW_READ;
      ram_addr_q <= '0;
      ram_rw_q   <= RW_READ;
      ram_din_q  <= '0;
      ack_q      <= 2'b00;
      dout0_q    <= '0;
      dout1_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      txn_rw_q   <= txn_rw_d;
      ram_addr_q <= ram_addr_d;
      ram_rw_q   <= ram_rw_d;
      ram_din_q  <= ram_din_d;
      ack_q      <= ack_d;
      dout0_q    <= dout0_d;
      dout1_q    <= dout1_d;
    end
  end

  assign ack0     = ack_q[0];
  assign ack1     = ack_q[1];
  assign dout0    = dout0_q;
  assign dout1    = dout1_q;
  assign busy     = (state_q != IDLE);
  assign ram_addr = ram_addr_q;
  assign ram_rw   = ram_rw_q;
  assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter with a genram-style RAM model attached.
module tb_ram_arbiter;

  localparam int AW = 9;
  localparam int DW = 12;

  logic          clk;
  logic          rstn;
  logic          req0, req1, rw0, rw1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0, din1;
  logic          ack0, ack1, busy;
  logic [DW-1:0] dout0, dout1;
  logic [AW-1:0] ram_addr;
  logic          ram_rw;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;
  int wr_cycles = 0;
  int ack0_pulses = 0;
  int ack1_pulses = 0;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req0     (req0),
    .req1     (req1),
    .rw0      (rw0),
    .rw1      (rw1),
    .addr0    (addr0),
    .addr1    (addr1),
    .din0     (din0),
    .din1     (din1),
    .ack0     (ack0),
    .ack1     (ack1),
    .dout0    (dout0),
    .dout1    (dout1),
    .busy     (busy),
    .ram_addr (ram_addr),
    .ram_rw   (ram_rw),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read, write when rw is low.
  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    if (ram_rw == 1'b0) mem[ram_addr] = ram_din;
  end

  always @(posedge clk) begin
    if (rstn && ram_rw == 1'b0) wr_cycles++;
  end

  always @(negedge clk) begin
    if (ack0 === 1'b1) ack0_pulses++;
    if (ack1 === 1'b1) ack1_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int a0_start, a1_start;

    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    ram_dout = '0;
    rstn = 1'b0;
    req0 = 1'b0; req1 = 1'b0; rw0 = 1'b1; rw1 = 1'b1;
    addr0 = '0; addr1 = '0; din0 = '0; din1 = '0;

    // ---------------- reset state
    tick(); tick();
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_dout0", dout0, 0);
    chk("rst_dout1", dout1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ram_rw", ram_rw, 1);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    rstn = 1'b1;
    tick();

    // ---------------- single write then read on port 0
    req0 = 1'b1; rw0 = 1'b0; addr0 = 9'h005; din0 = 12'hABC;
    tick();
    chk("wr_busy_k", busy, 1);
    chk("wr_ram_rw_k", ram_rw, 0);
    chk("wr_ram_addr_k", ram_addr, 9'h005);
    chk("wr_ram_din_k", ram_din, 12'hABC);
    tick();
    chk("wr_ram_rw_k1", ram_rw, 1);
    chk("wr_mem", mem[5], 12'hABC);
    chk("wr_ack0_k1", ack0, 0);
    tick();
    chk("wr_ack0_k2", ack0, 1);
    chk("wr_busy_k2", busy, 0);
    chk("wr_dout0_keep", dout0, 0);
    req0 = 1'b0;
    tick();
    chk("wr_ack0_fall", ack0, 0);

    req0 = 1'b1; rw0 = 1'b1; addr0 = 9'h005;
    tick();
    chk("rd_ram_rw", ram_rw, 1);
    chk("rd_ram_addr", ram_addr, 9'h005);
    tick(); tick();
    chk("rd_ack0", ack0, 1);
    chk("rd_dout0", dout0, 12'hABC);
    req0 = 1'b0;
    tick();
    chk("rd_dout0_hold", dout0, 12'hABC);
    chk("rd_ack0_fall", ack0, 0);
    chk("wr_cycles_1", wr_cycles, 1);

    // ---------------- contention after reset
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    mem[9'h010] = 12'h111;
    mem[9'h020] = 12'h222;
    req0 = 1'b1; rw0 = 1'b1; addr0 = 9'h010;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 9'h020;
    tick();
    chk("ct_first_addr", ram_addr, 9'h010);
    tick(); tick();
    chk("ct_ack0", ack0, 1);
    chk("ct_ack1_not", ack1, 0);
    chk("ct_dout0", dout0, 12'h111);
    req0 = 1'b0;
    tick();
    chk("ct_second_addr", ram_addr, 9'h020);
    chk("ct_busy", busy, 1);
    tick(); tick();
    chk("ct_ack1", ack1, 1);
    chk("ct_dout1", dout1, 12'h222);
    req1 = 1'b0;
    tick();

    // ---------------- continuous contention, 12 transactions
    a0_start = ack0_pulses;
    a1_start = ack1_pulses;
    req0 = 1'b1; req1 = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 12; c++) begin
      tick();
      if (ack0 || ack1) begin
        chk("alt_order", {ack1, ack0}, (n % 2 == 1) ? 2'b10 : 2'b01);
        if (ack1) chk("alt_dout1", dout1, 12'h222);
        else      chk("alt_dout0", dout0, 12'h111);
        n++;
        if (n == 12) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("alt_count", n, 12);
    tick();
    chk("alt_ack0_pulses", ack0_pulses - a0_start, 6);
    chk("alt_ack1_pulses", ack1_pulses - a1_start, 6);

    // ---------------- held request on port 1, ack mask
    mem[9'h001] = 12'h0A1;
    mem[9'h002] = 12'h0B2;
    a1_start = ack1_pulses;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 9'h001;
    tick();
    chk("hold_addr1", ram_addr, 9'h001);
    tick(); tick();
    chk("hold_ack1_a", ack1, 1);
    chk("hold_dout1_a", dout1, 12'h0A1);
    addr1 = 9'h002;
    tick();
    chk("hold_masked_busy", busy, 0);
    chk("hold_masked_ack", ack1, 0);
    tick();
    chk("hold_regrant_busy", busy, 1);
    chk("hold_addr2", ram_addr, 9'h002);
    tick(); tick();
    chk("hold_ack1_b", ack1, 1);
    chk("hold_dout1_b", dout1, 12'h0B2);
    req1 = 1'b0;
    tick(); tick(); tick();
    chk("hold_idle", busy, 0);
    chk("hold_pulses", ack1_pulses - a1_start, 2);

    // ---------------- reset during ACC
    mem[9'h030] = 12'h777;
    a0_start = ack0_pulses;
    req0 = 1'b1; rw0 = 1'b0; addr0 = 9'h030; din0 = 12'h5A5;
    tick();
    chk("rac_ram_rw_low", ram_rw, 0);
    #2;
    rstn = 1'b0;
    #1;
    chk("rac_ram_rw_async", ram_rw, 1);
    chk("rac_busy", busy, 0);
    chk("rac_ram_addr", ram_addr, 0);
    chk("rac_ram_din", ram_din, 0);
    chk("rac_dout1", dout1, 0);
    req0 = 1'b0;
    tick(); tick(); tick();
    chk("rac_mem_kept", mem[9'h030], 12'h777);
    chk("rac_no_ack", ack0_pulses - a0_start, 0);
    rstn = 1'b1;
    tick();

    // ---------------- write isolation
    mem[9'h0FF] = 12'h000;
    req0 = 1'b1; rw0 = 1'b0; addr0 = 9'h0FF; din0 = 12'h123;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 9'h0FF;
    tick();
    chk("iso_port0_wins", ram_rw, 0);
    tick(); tick();
    chk("iso_ack0", ack0, 1);
    chk("iso_dout0_keep", dout0, 0);
    req0 = 1'b0;
    tick(); tick(); tick();
    chk("iso_ack1", ack1, 1);
    chk("iso_dout1", dout1, 12'h123);
    req1 = 1'b0;
    tick();
    chk("iso_wr_cycles", wr_cycles, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
